// File: rtl/gray2bin_stream.sv
// gray2bin_stream: registered Gray-to-binary decoder with valid/ready handshake and single-bit step checking
module gray2bin_stream #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     gray_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 step_err,
    output logic                 is_repeat,
    output logic [ERR_CNT_W-1:0] err_count
);
    typedef enum logic {EMPTY, TRACK} state_t;
    state_t state;
    logic [WIDTH-1:0] prev_gray, bin_next, diff;
    logic accept, multi, same;
    // each binary bit is the parity of the Gray bits at and above it
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign bin_next[i] = ^gray_in[WIDTH-1:i];
    end
    // more than one bit set means the low set bit is not the only one
    always_comb begin
        diff     = gray_in ^ prev_gray;
        multi    = |(diff & (diff - WIDTH'(1)));
        same     = diff == '0;
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
    end
    // output register, step-tracking FSM and saturating error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            prev_gray <= '0;
            out_valid <= 1'b0;
            bin_out   <= '0;
            step_err  <= 1'b0;
            is_repeat <= 1'b0;
            err_count <= '0;
        end else if (accept) begin
            state     <= TRACK;
            prev_gray <= gray_in;
            out_valid <= 1'b1;
            bin_out   <= bin_next;
            step_err  <= state == TRACK && multi;
            is_repeat <= state == TRACK && same;
            if (state == TRACK && multi && !(&err_count))
                err_count <= err_count + ERR_CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gray2bin_stream.sv
// tb_gray2bin_stream: directed stimulus with a behavioural reference model and per-cycle compare
module tb_gray2bin_stream;
    logic       clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [3:0] gray_in = '0;
    logic       in_ready, out_valid, step_err, is_repeat;
    logic [3:0] bin_out;
    logic [7:0] err_count;
    int n_chk = 0, n_fail = 0;
    bit run = 0;

    // reference model state
    bit m_valid, m_err, m_rep, m_have;
    int m_bin, m_cnt, m_prev;

    gray2bin_stream #(.WIDTH(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .gray_in(gray_in), .out_valid(out_valid), .out_ready(out_ready),
        .bin_out(bin_out), .step_err(step_err), .is_repeat(is_repeat),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic int g2b(input int g);
        int b = 0;
        for (int k = 0; k < 4; k++) b ^= g >> k;
        return b & 15;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // model: what the outputs must be after each rising edge
    always @(posedge clk) begin
        if (reset) begin
            m_valid = 0; m_err = 0; m_rep = 0; m_have = 0;
            m_bin = 0; m_cnt = 0; m_prev = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            int d;
            d = $countones(4'(gray_in) ^ 4'(m_prev));
            m_bin = g2b(int'(gray_in));
            m_err = m_have && d >= 2;
            m_rep = m_have && d == 0;
            if (m_err && m_cnt < 255) m_cnt++;
            m_prev = int'(gray_in);
            m_have = 1;
            m_valid = 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (run) begin
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("in_ready", int'(in_ready), int'(!m_valid || out_ready));
            chk("err_count", int'(err_count), m_cnt);
            if (m_valid) begin
                chk("bin_out", int'(bin_out), m_bin);
                chk("step_err", int'(step_err), int'(m_err));
                chk("repeat", int'(is_repeat), int'(m_rep));
            end
        end
    end

    task automatic drive(input bit v, input logic [3:0] g, input bit r);
        in_valid = v; gray_in = g; out_ready = r;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; out_ready = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        logic [3:0] seq1 [5];
        seq1 = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
        do_reset();
        run = 1;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst err_count", int'(err_count), 0);
        chk("rst bin_out", int'(bin_out), 0);
        // 1: back-to-back
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; gray_in = seq1[i]; out_ready = 1; #1;
            chk("t1 in_ready", int'(in_ready), 1);
            @(posedge clk); #1;
            chk("t1 bin", int'(bin_out), i);
            chk("t1 step_err", int'(step_err), 0);
            chk("t1 repeat", int'(is_repeat), 0);
        end
        // 2: exhaustive walk plus wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] b;
            b = 4'(i);
            drive(1, b ^ (b >> 1), 1);
            chk("t2 bin", int'(bin_out), i);
            chk("t2 step_err", int'(step_err), 0);
        end
        drive(1, 4'b0000, 1);
        chk("t2 wrap bin", int'(bin_out), 0);
        chk("t2 wrap step_err", int'(step_err), 0);
        chk("t2 err_count", int'(err_count), 0);
        // 3: illegal jump then re-sync
        do_reset();
        drive(1, 4'b0000, 1);
        drive(1, 4'b0011, 1);
        chk("t3 bin", int'(bin_out), 2);
        chk("t3 step_err", int'(step_err), 1);
        chk("t3 err_count", int'(err_count), 1);
        drive(1, 4'b0010, 1);
        chk("t3 resync step_err", int'(step_err), 0);
        chk("t3 resync bin", int'(bin_out), 3);
        // 4: backpressure
        do_reset();
        drive(1, 4'b0001, 1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; gray_in = 4'b0011; out_ready = 0; #1;
            chk("t4 in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
            chk("t4 held valid", int'(out_valid), 1);
            chk("t4 held bin", int'(bin_out), 1);
        end
        drive(1, 4'b0011, 1);
        chk("t4 bin", int'(bin_out), 2);
        chk("t4 step_err", int'(step_err), 0);
        drive(0, 4'b0011, 1);
        chk("t4 drained", int'(out_valid), 0);
        // 5: repeat and saturation
        do_reset();
        drive(1, 4'b0110, 1);
        drive(1, 4'b0110, 1);
        chk("t5 repeat", int'(is_repeat), 1);
        chk("t5 step_err", int'(step_err), 0);
        for (int i = 0; i < 300; i++) drive(1, (i % 2) ? 4'b1111 : 4'b0000, 1);
        chk("t5 saturated", int'(err_count), 255);
        chk("t5 last step_err", int'(step_err), 1);
        // 6: reset with a pending output
        drive(1, 4'b0101, 0);
        drive(0, 4'b0101, 0);
        chk("t6 pending", int'(out_valid), 1);
        reset = 1; in_valid = 0;
        @(posedge clk); #1;
        reset = 0;
        chk("t6 out_valid", int'(out_valid), 0);
        chk("t6 err_count", int'(err_count), 0);
        drive(1, 4'b1111, 1);
        chk("t6 first step_err", int'(step_err), 0);
        chk("t6 first bin", int'(bin_out), 10);
        drive(0, 4'b0000, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
